// File: rtl/serial_pkg.sv
// Shared constants for the serial transmitter: FSM state encoding and line levels.
package serial_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_START = 2'd1;
   localparam state_t ST_DATA  = 2'd2;
   localparam state_t ST_STOP  = 2'd3;

   localparam int   FRAME_BITS = 10;
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_out_fifo.sv
// Byte FIFO between the CPU write port and the transmitter; count is the registered occupancy.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          m_clock,
   input  logic          p_reset,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge m_clock) begin
      if (!p_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge m_clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/serial_out.sv
// 8N1 UART transmitter: buffers CPU bytes in a small FIFO and drives the TXD pin.
module serial_out
   import serial_pkg::*;
#(
   parameter int CLKDIV = 16,
   parameter int DEPTH  = 4,
   parameter int AW     = 2
) (
   input  logic       m_clock,
   input  logic       p_reset,
   input  logic [7:0] data,
   input  logic       port_write,
   output logic       txready,
   output logic       busy,
   output logic       overflow,
   output logic       txd,
   output logic [1:0] state_dbg
);

   localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

   state_t        state;
   logic [DW-1:0] div;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic          bit_end;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic          fifo_full;
   logic [7:0]    fifo_dout;
   logic [AW:0]   fifo_count;

   // Handshake: a byte is taken on an edge where port_write=1 and txready=1;
   // txready comes from the registered count, so a same-cycle pop never frees a slot early.
   assign txready   = ~fifo_full;
   assign push      = port_write & ~fifo_full;
   assign bit_end   = (div == DIV_LAST);
   assign pop       = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));
   assign busy      = (state != ST_IDLE) | (fifo_count != '0);
   assign state_dbg = state;

   sync_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .push    (push),
      .pop     (pop),
      .din     (data),
      .dout    (fifo_dout),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   always_ff @(posedge m_clock) begin
      if (!p_reset)
         overflow <= 1'b0;
      else if (port_write && fifo_full)
         overflow <= 1'b1;
   end

   // txd is loaded one edge ahead with the level of the bit that starts next.
   always_ff @(posedge m_clock) begin
      if (!p_reset) begin
         state  <= ST_IDLE;
         div    <= '0;
         bitcnt <= '0;
         shreg  <= '0;
         txd    <= IDLE_LEVEL;
      end else begin
         case (state)
            ST_IDLE: begin
               txd <= IDLE_LEVEL;
               div <= '0;
               if (!fifo_empty) begin
                  shreg <= fifo_dout;
                  txd   <= 1'b0;
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  div    <= '0;
                  bitcnt <= '0;
                  txd    <= shreg[0];
                  state  <= ST_DATA;
               end else begin
                  div <= div + 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  div <= '0;
                  if (bitcnt == 3'd7) begin
                     txd   <= IDLE_LEVEL;
                     state <= ST_STOP;
                  end else begin
                     shreg  <= {1'b0, shreg[7:1]};
                     bitcnt <= bitcnt + 1'b1;
                     txd    <= shreg[1];
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  div <= '0;
                  if (!fifo_empty) begin
                     shreg <= fifo_dout;
                     txd   <= 1'b0;
                     state <= ST_START;
                  end else begin
                     txd   <= IDLE_LEVEL;
                     state <= ST_IDLE;
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            default: begin
               txd   <= IDLE_LEVEL;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_out.sv
// Bench for serial_out: queue-based line model checked every cycle, a bit-sampling receiver, directed tests.
module tb_serial_out;

   localparam int CLKDIV = 4;
   localparam int DEPTH  = 4;
   localparam int AW     = 2;

   logic       m_clock = 1'b0;
   logic       p_reset = 1'b0;
   logic [7:0] data = 8'h00;
   logic       port_write = 1'b0;
   logic       txready;
   logic       busy;
   logic       overflow;
   logic       txd;
   logic [1:0] state_dbg;

   serial_out #(.CLKDIV(CLKDIV), .DEPTH(DEPTH), .AW(AW)) dut (
      .m_clock    (m_clock),
      .p_reset    (p_reset),
      .data       (data),
      .port_write (port_write),
      .txready    (txready),
      .busy       (busy),
      .overflow   (overflow),
      .txd        (txd),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   always #5 m_clock = ~m_clock;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_reset_cyc = -1;
   bit   model_valid = 1'b0;

   // model: bytes waiting, and the line levels still to be driven for the frame in flight
   logic [7:0] m_fifo[$];
   logic       line_q[$];
   logic       m_txd = 1'b1;
   logic       m_active = 1'b0;
   logic       m_ovf = 1'b0;

   // scoreboard
   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];
   int         rx_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      int pre;
      logic [7:0] b;
      cyc++;
      if (!p_reset) begin
         m_fifo.delete();
         line_q.delete();
         m_txd = 1'b1;
         m_active = 1'b0;
         m_ovf = 1'b0;
         last_reset_cyc = cyc;
         model_valid = 1'b1;
         return;
      end
      pre = m_fifo.size();
      if (line_q.size() == 0 && pre > 0) begin
         b = m_fifo.pop_front();
         exp_q.push_back(b);
         for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < CLKDIV; j++) begin
               if (i == 0)
                  line_q.push_back(1'b0);
               else if (i == 9)
                  line_q.push_back(1'b1);
               else
                  line_q.push_back(b[i-1]);
            end
         end
      end
      m_active = (line_q.size() != 0);
      m_txd = m_active ? line_q.pop_front() : 1'b1;
      if (port_write) begin
         if (pre < DEPTH)
            m_fifo.push_back(data);
         else
            m_ovf = 1'b1;
      end
   endtask

   initial forever begin
      @(posedge m_clock);
      model_step();
   end

   // compare process
   initial forever begin
      @(negedge m_clock);
      if (model_valid) begin
         check("txd", txd, m_txd);
         check("busy", busy, m_active || m_fifo.size() != 0);
         check("txready", txready, m_fifo.size() < DEPTH);
         check("overflow", overflow, m_ovf);
         check("fsm_active", state_dbg != 2'd0, m_active);
      end
   end

   // receiver: samples each bit in its centre
   initial begin : rx
      int start;
      logic [7:0] b;
      logic stop_bit;
      logic [7:0] dummy;
      forever begin
         @(negedge m_clock);
         if (model_valid && p_reset && txd === 1'b0) begin
            start = cyc;
            repeat (CLKDIV + CLKDIV/2) @(negedge m_clock);
            for (int k = 0; k < 8; k++) begin
               b[k] = txd;
               if (k < 7) repeat (CLKDIV) @(negedge m_clock);
            end
            repeat (CLKDIV) @(negedge m_clock);
            stop_bit = txd;
            if (last_reset_cyc > start) begin
               if (exp_q.size() != 0) dummy = exp_q.pop_front();
            end else begin
               rx_count++;
               rx_log.push_back(b);
               check("rx_stop", stop_bit, 1'b1);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rx_unexpected: cycle %0d got %0h expected no byte", cyc, b);
               end else begin
                  check("rx_byte", b, exp_q.pop_front());
               end
            end
         end
      end
   end

   // driver tasks
   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge m_clock);
         #1;
      end
   endtask

   task automatic step_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic put(input logic [7:0] b);
      port_write = 1'b1;
      data = b;
      step();
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy !== 1'b0 || m_active || m_fifo.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check("idle_timeout", n < budget, 1'b1);
      step(CLKDIV * 3);
   endtask

   function automatic logic [7:0] rx_back(input int k);
      if (rx_log.size() > k) return rx_log[rx_log.size()-1-k];
      return 8'hxx;
   endfunction

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog: cycle %0d got no finish expected finish", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int w;
      int rx0;

      // reset state
      p_reset = 1'b0;
      step(3);
      check("rst_txd", txd, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_txready", txready, 1'b1);
      check("rst_overflow", overflow, 1'b0);
      check("rst_state", state_dbg, 2'd0);
      p_reset = 1'b1;
      step(5);

      // single byte 0x41: bits LSB first 1,0,0,0,0,0,1,0
      w = cyc + 1;
      put(8'h41);
      port_write = 1'b0;
      step_to(w+1);  check("sb_start", txd, 1'b0); check("sb_busy", busy, 1'b1);
      step_to(w+4);  check("sb_start_end", txd, 1'b0);
      step_to(w+5);  check("sb_bit0", txd, 1'b1);
      step_to(w+9);  check("sb_bit1", txd, 1'b0);
      step_to(w+29); check("sb_bit6", txd, 1'b1);
      step_to(w+33); check("sb_bit7", txd, 1'b0);
      step_to(w+37); check("sb_stop", txd, 1'b1);
      step_to(w+40); check("sb_busy_last", busy, 1'b1);
      step_to(w+41); check("sb_busy_fall", busy, 1'b0);
      wait_idle(200);
      check("sb_rx", rx_back(0), 8'h41);

      // back-to-back 0x55, 0xAA: second start bit immediately after first stop bit
      rx0 = rx_count;
      w = cyc + 1;
      put(8'h55);
      put(8'hAA);
      port_write = 1'b0;
      step_to(w+40); check("b2b_stop1", txd, 1'b1);
      step_to(w+41); check("b2b_start2", txd, 1'b0); check("b2b_busy_mid", busy, 1'b1);
      step_to(w+45); check("b2b_aa_bit0", txd, 1'b0);
      step_to(w+49); check("b2b_aa_bit1", txd, 1'b1);
      step_to(w+80); check("b2b_busy_last", busy, 1'b1);
      step_to(w+81); check("b2b_busy_fall", busy, 1'b0);
      wait_idle(300);
      check("b2b_count", rx_count - rx0, 2);
      check("b2b_rx0", rx_back(1), 8'h55);
      check("b2b_rx1", rx_back(0), 8'hAA);

      // full / overflow: six consecutive writes while idle
      rx0 = rx_count;
      for (int i = 0; i < 6; i++) begin
         put(8'(8'h60 + i));
         if (i == 4) begin
            check("ovf_txready_low", txready, 1'b0);
            check("ovf_not_yet", overflow, 1'b0);
         end
         if (i == 5) check("ovf_set", overflow, 1'b1);
      end
      port_write = 1'b0;
      step();
      check("ovf_sticky", overflow, 1'b1);
      wait_idle(1000);
      check("ovf_frames", rx_count - rx0, 5);
      check("ovf_still_set", overflow, 1'b1);
      for (int i = 0; i < 5; i++)
         check("ovf_order", rx_back(4 - i), 8'(8'h60 + i));

      // reset during data bit 3 of 0xFF
      rx0 = rx_count;
      w = cyc + 1;
      put(8'hFF);
      port_write = 1'b0;
      step_to(w+18);
      check("rm_bit3", txd, 1'b1);
      check("rm_state_data", state_dbg, 2'd2);
      p_reset = 1'b0;
      step();
      check("rm_txd", txd, 1'b1);
      check("rm_busy", busy, 1'b0);
      check("rm_overflow", overflow, 1'b0);
      check("rm_txready", txready, 1'b1);
      p_reset = 1'b1;
      step(60);
      check("rm_no_frame", rx_count - rx0, 0);
      check("rm_line_idle", txd, 1'b1);

      // wrap-around: 10 bytes at the rate txready allows
      rx0 = rx_count;
      for (int i = 0; i < 10; i++) begin
         int n = 0;
         while (txready !== 1'b1 && n < 500) begin
            step();
            n++;
         end
         check("wrap_ready_timeout", n < 500, 1'b1);
         put(8'(8'h30 + i));
         port_write = 1'b0;
      end
      wait_idle(2000);
      check("wrap_count", rx_count - rx0, 10);
      check("wrap_overflow", overflow, 1'b0);
      for (int i = 0; i < 10; i++)
         check("wrap_order", rx_back(9 - i), 8'(8'h30 + i));

      // "OK\n"
      rx0 = rx_count;
      put(8'h4F);
      put(8'h4B);
      put(8'h0A);
      port_write = 1'b0;
      wait_idle(500);
      check("ok_count", rx_count - rx0, 3);
      check("ok_O", rx_back(2), 8'h4F);
      check("ok_K", rx_back(1), 8'h4B);
      check("ok_nl", rx_back(0), 8'h0A);

      // final report
      check("exp_q_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
